// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter_if
// Brief    : Request/response bundle between the requesters and the shared
//            ALU arbiter. Requester i uses bit i of each per-requester vector
//            and slice [i*WIDTH +: WIDTH] of the packed operand buses.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_arbiter_if #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 32
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_op1;
  logic [NREQ*WIDTH-1:0] req_op2;
  logic [NREQ-1:0]       req_ctrl;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic [WIDTH-1:0]      rsp_data;
  logic                  rsp_eq;

  // Requester side
  modport master (
    output req_valid, req_op1, req_op2, req_ctrl, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_eq
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_op1, req_op2, req_ctrl, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_eq
  );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Brief    : Shares one combinational add/compare ALU between NREQ requesters.
//            One transaction in flight: IDLE (grant) -> EXEC (capture ALU
//            result) -> RESP (hold response until owner accepts).
//            Arbitration is round-robin by default; defining the macro
//            ALU_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins).
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  alu_arbiter_if.slave     bus,
  output logic [WIDTH-1:0] alu_op1,
  output logic [WIDTH-1:0] alu_op2,
  output logic             alu_ctrl,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_eq,
  output logic             busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [WIDTH-1:0] alu_op1_q, alu_op1_d;
  logic [WIDTH-1:0] alu_op2_q, alu_op2_d;
  logic             alu_ctrl_q, alu_ctrl_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_eq_q, rsp_eq_d;

  logic             grant_found;
  logic [IW-1:0]    grant_idx;

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic [IW-1:0]    ptr_q, ptr_d;
`endif

  // Pick the winning requester for this cycle
  always_comb begin : p_grant
    int cand;
    cand        = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      cand = i;
`else
      // Search upward from the pointer, wrapping at NREQ
      cand = int'(ptr_q) + i;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
`endif
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = IW'(cand);
      end
    end
  end

  // Offer ready to the winner only while idle; held low during reset
  always_comb begin
    bus.req_ready = '0;
    if ((state_q == S_IDLE) && !rst && grant_found) begin
      bus.req_ready[grant_idx] = 1'b1;
    end
  end

  // Response valid goes only to the owner of the in-flight transaction
  always_comb begin
    bus.rsp_valid = '0;
    if (state_q == S_RESP) begin
      bus.rsp_valid[owner_q] = 1'b1;
    end
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    alu_op1_d  = alu_op1_q;
    alu_op2_d  = alu_op2_q;
    alu_ctrl_d = alu_ctrl_q;
    rsp_data_d = rsp_data_q;
    rsp_eq_d   = rsp_eq_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
    ptr_d      = ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        // A grant is always a handshake: ready is driven to the valid winner
        if (grant_found) begin
          alu_op1_d  = bus.req_op1[grant_idx*WIDTH +: WIDTH];
          alu_op2_d  = bus.req_op2[grant_idx*WIDTH +: WIDTH];
          alu_ctrl_d = bus.req_ctrl[grant_idx];
          owner_d    = grant_idx;
`ifndef ALU_ARB_FIXED_PRIO_EN
          ptr_d      = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
`endif
          state_d    = S_EXEC;
        end
      end
      S_EXEC: begin
        // Both result fields copied verbatim from the ALU
        rsp_data_d = alu_out;
        rsp_eq_d   = alu_eq;
        state_d    = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready[owner_q]) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      owner_q    <= '0;
      alu_op1_q  <= '0;
      alu_op2_q  <= '0;
      alu_ctrl_q <= 1'b0;
      rsp_data_q <= '0;
      rsp_eq_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      alu_op1_q  <= alu_op1_d;
      alu_op2_q  <= alu_op2_d;
      alu_ctrl_q <= alu_ctrl_d;
      rsp_data_q <= rsp_data_d;
      rsp_eq_q   <= rsp_eq_d;
    end
  end

`ifndef ALU_ARB_FIXED_PRIO_EN
  // Round-robin pointer register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  assign alu_op1      = alu_op1_q;
  assign alu_op2      = alu_op2_q;
  assign alu_ctrl     = alu_ctrl_q;
  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_eq   = rsp_eq_q;
  assign busy         = (state_q != S_IDLE);

endmodule
`default_nettype wire
